// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: HI/LO registers, fixed-latency mult/div timing
// and the stall request for colliding D-stage HI/LO instructions.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  multctrl,
  input  logic [1:0]  muwe,
  input  logic [1:0]  mure,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        ismu_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   hi;
  logic [31:0]   lo;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_we;

  logic          op_valid;
  logic          is_div;
  logic          is_sdiv;
  logic          div_zero;
  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [31:0]   safe_b;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   quo;
  logic [31:0]   rem;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;

  // Result of the operation being issued; signed divide works on magnitudes so
  // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
  always_comb begin
    op_valid = (multctrl[2] == 1'b0);
    is_div   = (multctrl[1] == 1'b1);
    is_sdiv  = (multctrl == 3'b010);
    div_zero = (rt_data == 32'd0);
    prod_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
    abs_a    = (is_sdiv && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
    abs_b    = (is_sdiv && rt_data[31]) ? (32'd0 - rt_data) : rt_data;
    safe_b   = div_zero ? 32'd1 : abs_b;
    uq       = abs_a / safe_b;
    ur       = abs_a % safe_b;
    quo      = (is_sdiv && (rs_data[31] ^ rt_data[31])) ? (32'd0 - uq) : uq;
    rem      = (is_sdiv && rs_data[31]) ? (32'd0 - ur) : ur;
    case (multctrl)
      3'b000:  {res_hi, res_lo} = prod_s;
      3'b001:  {res_hi, res_lo} = prod_u;
      3'b010,
      3'b011:  {res_hi, res_lo} = {rem, quo};
      default: {res_hi, res_lo} = 64'd0;
    endcase
  end

  // Issue/run/commit state machine plus HI/LO architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && op_valid) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= !(is_div && div_zero);
            count   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (!start && muwe == 2'b01) begin
            hi <= rs_data;
          end else if (!start && muwe == 2'b10) begin
            lo <= rs_data;
          end else begin
            count <= '0;
          end
        end
        RUN: begin
          if (count == CW'(1)) begin
            count <= '0;
            busy  <= 1'b0;
            state <= IDLE;
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // HI/LO read port and hazard stall request.
  always_comb begin
    case (mure)
      2'b01:   rdata = hi;
      2'b10:   rdata = lo;
      default: rdata = 32'd0;
    endcase
    stall = ismu_d & (busy | start);
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  multctrl;
  logic [1:0]  muwe;
  logic [1:0]  mure;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        ismu_d;
  logic        busy;
  logic        stall;
  logic [31:0] rdata;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .multctrl(multctrl),
    .muwe(muwe), .mure(mure), .rs_data(rs_data), .rt_data(rt_data),
    .ismu_d(ismu_d), .busy(busy), .stall(stall), .rdata(rdata)
  );

  typedef struct {
    string       name;
    bit          c_rd;
    logic [31:0] rd;
    bit          c_busy;
    logic        b;
    bit          c_stall;
    logic        s;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(string n, bit crd, logic [31:0] rd, bit cb, logic b, bit cs, logic s);
    exp_t e;
    e.name = n; e.c_rd = crd; e.rd = rd; e.c_busy = cb; e.b = b; e.c_stall = cs; e.s = s;
    return e;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue its expectations.
  task automatic step(input logic rst, input logic st, input logic [2:0] mc,
                      input logic [1:0] we, input logic [1:0] re,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic id, input exp_t e);
    @(posedge clk);
    #1;
    reset = rst; start = st; multctrl = mc; muwe = we; mure = re;
    rs_data = a; rt_data = b; ismu_d = id;
    q.push_back(e);
  endtask

  task automatic read_hilo(input logic [31:0] h, input logic [31:0] l, input string n);
    step(1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 32'd0, 32'd0, 1'b0, ex({n, "_hi"}, 1, h, 1, 1'b0, 1, 1'b0));
    step(1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 32'd0, 32'd0, 1'b0, ex({n, "_lo"}, 1, l, 1, 1'b0, 1, 1'b0));
  endtask

  // Issue one op, check busy/stall every busy cycle, optionally inject a
  // spurious start or a HI/LO write at given busy-cycle indices, then read back.
  task automatic run_op(input logic [2:0] mc, input logic [31:0] a, input logic [31:0] b,
                        input logic id, input int n, input logic [31:0] h, input logic [31:0] l,
                        input string nm, input int st_at, input int we_at, input logic [1:0] we_sel);
    step(1'b0, 1'b1, mc, 2'b00, 2'b00, a, b, id, ex({nm, "_issue"}, 0, 32'd0, 1, 1'b0, 1, id));
    for (int i = 0; i < n; i++) begin
      step(1'b0, (i == st_at), (i == st_at) ? 3'b010 : 3'b000,
           (i == we_at) ? we_sel : 2'b00, 2'b00, 32'hDEAD_0000 | 32'(i), 32'h0000_0003,
           id, ex({nm, "_busy"}, 0, 32'd0, 1, 1'b1, 1, id));
    end
    read_hilo(h, l, nm);
  endtask

  // Scoreboard monitor: compare whatever the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.c_rd) begin
          n_checks++;
          if (rdata !== e.rd) begin
            n_fail++;
            $display("FAIL %s rdata actual=%h required=%h", e.name, rdata, e.rd);
          end
        end
        if (e.c_busy) begin
          n_checks++;
          if (busy !== e.b) begin
            n_fail++;
            $display("FAIL %s busy actual=%b required=%b", e.name, busy, e.b);
          end
        end
        if (e.c_stall) begin
          n_checks++;
          if (stall !== e.s) begin
            n_fail++;
            $display("FAIL %s stall actual=%b required=%b", e.name, stall, e.s);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; multctrl = 3'b000; muwe = 2'b00; mure = 2'b00;
    rs_data = 32'd0; rt_data = 32'd0; ismu_d = 1'b0;
    step(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("rst", 0, 32'd0, 0, 1'b0, 0, 1'b0));
    step(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("rst", 0, 32'd0, 0, 1'b0, 0, 1'b0));
    read_hilo(32'h0000_0000, 32'h0000_0000, "reset");

    // multu with a spurious start mid-run, ismu_d held high for stall checks
    run_op(3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 5, 32'h0000_0001, 32'hFFFF_FFFE, "multu", 2, -1, 2'b00);
    run_op(3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult", -1, -1, 2'b00);
    run_op(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg", -1, -1, 2'b00);
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", -1, -1, 2'b00);
    run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_zero_mthi", -1, 9, 2'b01);
    run_op(3'b011, 32'h0000_0007, 32'h0000_0000, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "divu_zero_mtlo", -1, 3, 2'b10);
    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 10, 32'h0000_0001, 32'hFFFF_FFFD, "div_rem", -1, -1, 2'b00);
    run_op(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 1'b0, 10, 32'h0000_000F, 32'h0FFF_FFFF, "divu", -1, -1, 2'b00);

    // mthi/mtlo in IDLE; a same-cycle read returns the old value
    step(1'b0, 1'b0, 3'b000, 2'b01, 2'b01, 32'h1234_5678, 32'd0, 1'b0, ex("mthi_old", 1, 32'h0000_000F, 1, 1'b0, 1, 1'b0));
    step(1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 32'd0, 32'd0, 1'b0, ex("mthi_new", 1, 32'h1234_5678, 1, 1'b0, 0, 1'b0));
    step(1'b0, 1'b0, 3'b000, 2'b10, 2'b10, 32'h0BAD_CAFE, 32'd0, 1'b0, ex("mtlo_old", 1, 32'h0FFF_FFFF, 0, 1'b0, 0, 1'b0));
    read_hilo(32'h1234_5678, 32'h0BAD_CAFE, "mtlo");

    // invalid op selects are no-ops
    step(1'b0, 1'b1, 3'b100, 2'b00, 2'b00, 32'h5, 32'h3, 1'b1, ex("inv100", 0, 32'd0, 1, 1'b0, 1, 1'b1));
    step(1'b0, 1'b1, 3'b111, 2'b00, 2'b00, 32'h5, 32'h3, 1'b0, ex("inv111", 0, 32'd0, 1, 1'b0, 1, 1'b0));
    read_hilo(32'h1234_5678, 32'h0BAD_CAFE, "invalid");

    // start wins over muwe; div overflow case
    step(1'b0, 1'b1, 3'b010, 2'b01, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, ex("ovf_issue", 0, 32'd0, 1, 1'b0, 0, 1'b0));
    step(1'b0, 1'b0, 3'b000, 2'b00, 2'b01, 32'd0, 32'd0, 1'b0, ex("start_beats_muwe", 1, 32'h1234_5678, 1, 1'b1, 0, 1'b0));
    for (int i = 1; i < 10; i++)
      step(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("ovf_busy", 0, 32'd0, 1, 1'b1, 1, 1'b0));
    read_hilo(32'h0000_0000, 32'h8000_0000, "div_ovf");

    // reset while counter=3 aborts the divide
    step(1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 32'd100, 32'd7, 1'b0, ex("abort_issue", 0, 32'd0, 1, 1'b0, 0, 1'b0));
    for (int i = 0; i < 7; i++)
      step(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("abort_busy", 0, 32'd0, 1, 1'b1, 0, 1'b0));
    step(1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("abort_rst", 0, 32'd0, 1, 1'b1, 0, 1'b0));
    read_hilo(32'h0000_0000, 32'h0000_0000, "abort");
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, ex("abort_idle", 0, 32'd0, 1, 1'b0, 0, 1'b0));
    read_hilo(32'h0000_0000, 32'h0000_0000, "abort_late");

    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
